// File: rtl/unibus_pkg.sv
// Shared UNIBUS definitions: cycle-type encodings, BR levels and the CSR
// address / vector assignments of the serial and clock slaves on this bus.
package unibus_pkg;

    // {C1, C0} cycle-type encoding
    typedef enum logic [1:0] {
        CYC_DATI  = 2'b00,
        CYC_DATIP = 2'b01,
        CYC_DATO  = 2'b10,
        CYC_DATOB = 2'b11
    } cyc_t;

    localparam int BR4 = 4;
    localparam int BR5 = 5;
    localparam int BR6 = 6;
    localparam int BR7 = 7;

    localparam logic [17:0] KW11L_LKS_ADDR     = 18'o777546;
    localparam logic [15:0] KW11L_VEC          = 16'o100;
    localparam logic [17:0] KL11_CSR_ADDR      = 18'o777560;
    localparam logic [15:0] KL11_VEC           = 16'o060;
    localparam logic [17:0] DL11_TU58_CSR_ADDR = 18'o776500;
    localparam logic [15:0] DL11_TU58_VEC      = 16'o300;

    // Word match: byte-address bit 0 never selects a different register.
    function automatic logic word_match(input logic [17:0] addr, input logic [17:0] base);
        return addr[17:1] == base[17:1];
    endfunction

endpackage

// File: rtl/kw11l_tick.sv
// Line-time prescaler: counts 0..DIV-1 while enabled and pulses tick on the
// wrap cycle so the consumer can act on the following edge.
module kw11l_tick #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = enable && (cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      cnt <= '0;
        else if (clear)  cnt <= '0;
        else if (tick)   cnt <= '0;
        else if (enable) cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/kw11l.sv
// KW11-L line-time clock: UNIBUS slave exposing LKS (MON, IE) and a BR6
// interrupt requester that becomes bus master to hand the CPU its vector.
module kw11l
    import unibus_pkg::*;
#(
    parameter logic [17:0] ADDR    = KW11L_LKS_ADDR,
    parameter logic [15:0] VEC     = KW11L_VEC,
    parameter int          CLK_HZ  = 50000000,
    parameter int          LINE_HZ = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        bus_init,
    input  logic [15:0] bus_d,
    input  logic [17:0] bus_addr,
    input  logic        bus_c0,
    input  logic        bus_c1,
    input  logic        bus_bbsy,
    input  logic        bus_msyn,
    input  logic        bus_ssyn,
    input  logic        bus_sack,
    input  logic        bus_intr,
    input  logic [7:4]  bus_bg_in,
    output logic [7:4]  bus_bg_out,
    output logic [7:4]  bus_br,
    output logic        bus_ssyn_out,
    output logic        bus_sack_out,
    output logic        bus_bbsy_out,
    output logic        bus_intr_out,
    output logic [15:0] bus_d_out
);

    typedef enum logic {S_IDLE, S_ACK} s_state_t;
    typedef enum logic [1:0] {I_IDLE, I_REQ, I_GRANT, I_MASTER} i_state_t;

    s_state_t    s_state;
    i_state_t    i_state;
    cyc_t        cyc;
    logic        mon, ie, mon_ie, mon_ie_q;
    logic        tick, entry, is_write;
    logic        br6;
    logic [15:0] rd_data, vec_data;

    // Other bus state is observed by other slaves, not by this one.
    logic unused;
    assign unused = ^{bus_intr, bus_sack, bus_d[15:8], bus_d[5:0]};

    assign cyc      = cyc_t'({bus_c1, bus_c0});
    assign entry    = (s_state == S_IDLE) && bus_msyn && word_match(bus_addr, ADDR);
    // A DATOB to the odd (high) byte touches nothing in LKS.
    assign is_write = (cyc == CYC_DATO) || (cyc == CYC_DATOB && !bus_addr[0]);
    assign mon_ie   = mon & ie;

    kw11l_tick #(.DIV(CLK_HZ / LINE_HZ)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .clear  (bus_init),
        .enable (enable),
        .tick   (tick)
    );

    // LKS: a write of MON=0 lands after the tick so it wins on a shared edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mon <= 1'b0;
            ie  <= 1'b0;
        end else if (bus_init) begin
            mon <= 1'b0;
            ie  <= 1'b0;
        end else begin
            if (tick) mon <= 1'b1;
            if (entry && is_write) begin
                ie <= bus_d[6];
                if (!bus_d[7]) mon <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_state      <= S_IDLE;
            bus_ssyn_out <= 1'b0;
            rd_data      <= '0;
        end else if (bus_init) begin
            s_state      <= S_IDLE;
            bus_ssyn_out <= 1'b0;
            rd_data      <= '0;
        end else begin
            case (s_state)
                S_IDLE: if (entry) begin
                    s_state      <= S_ACK;
                    bus_ssyn_out <= 1'b1;
                    rd_data      <= bus_c1 ? 16'h0000 : {8'h00, mon, ie, 6'b000000};
                end
                S_ACK: if (!bus_msyn) begin
                    s_state      <= S_IDLE;
                    bus_ssyn_out <= 1'b0;
                    rd_data      <= '0;
                end
                default: s_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i_state      <= I_IDLE;
            mon_ie_q     <= 1'b0;
            br6          <= 1'b0;
            bus_sack_out <= 1'b0;
            bus_bbsy_out <= 1'b0;
            bus_intr_out <= 1'b0;
            vec_data     <= '0;
        end else if (bus_init) begin
            i_state      <= I_IDLE;
            mon_ie_q     <= 1'b0;
            br6          <= 1'b0;
            bus_sack_out <= 1'b0;
            bus_bbsy_out <= 1'b0;
            bus_intr_out <= 1'b0;
            vec_data     <= '0;
        end else begin
            mon_ie_q <= mon_ie;
            case (i_state)
                I_IDLE: if (mon_ie && !mon_ie_q) begin
                    i_state <= I_REQ;
                    br6     <= 1'b1;
                end
                I_REQ: if (!mon_ie) begin
                    i_state <= I_IDLE;
                    br6     <= 1'b0;
                end else if (bus_bg_in[BR6]) begin
                    i_state      <= I_GRANT;
                    br6          <= 1'b0;
                    bus_sack_out <= 1'b1;
                end
                // Wait for the previous master and its slave to let go.
                I_GRANT: if (!bus_bbsy && !bus_ssyn) begin
                    i_state      <= I_MASTER;
                    bus_sack_out <= 1'b0;
                    bus_bbsy_out <= 1'b1;
                    bus_intr_out <= 1'b1;
                    vec_data     <= VEC;
                end
                I_MASTER: if (bus_ssyn) begin
                    i_state      <= I_IDLE;
                    bus_bbsy_out <= 1'b0;
                    bus_intr_out <= 1'b0;
                    vec_data     <= '0;
                end
                default: i_state <= I_IDLE;
            endcase
        end
    end

    assign bus_br     = {1'b0, br6, 2'b00};
    assign bus_bg_out = {bus_bg_in[7], bus_bg_in[6] & (i_state == I_IDLE), bus_bg_in[5:4]};
    // Slave reads need the CPU as master, so the two sources never overlap.
    assign bus_d_out  = rd_data | vec_data;

endmodule

// File: tb/tb_kw11l.sv
// Randomized scoreboard bench for kw11l with a cycle-level LKS/interrupt model.
module tb_kw11l;
    import unibus_pkg::*;

    localparam int          DIV  = 10;
    localparam logic [17:0] ADDR = KW11L_LKS_ADDR;

    logic        clk = 1'b0, reset = 1'b0, enable = 1'b0, bus_init = 1'b0;
    logic [15:0] bus_d = '0;
    logic [17:0] bus_addr = '0;
    logic        bus_c0 = 1'b0, bus_c1 = 1'b0;
    logic        bus_bbsy = 1'b0, bus_msyn = 1'b0, bus_ssyn = 1'b0, bus_sack = 1'b0, bus_intr = 1'b0;
    logic [7:4]  bus_bg_in = '0;
    logic [7:4]  bg_out, br;
    logic        ssyn_out, sack_out, bbsy_out, intr_out;
    logic [15:0] d_out;

    kw11l #(.ADDR(ADDR), .VEC(KW11L_VEC), .CLK_HZ(600), .LINE_HZ(60)) dut (
        .clk(clk), .reset(reset), .enable(enable), .bus_init(bus_init),
        .bus_d(bus_d), .bus_addr(bus_addr), .bus_c0(bus_c0), .bus_c1(bus_c1),
        .bus_bbsy(bus_bbsy), .bus_msyn(bus_msyn), .bus_ssyn(bus_ssyn),
        .bus_sack(bus_sack), .bus_intr(bus_intr), .bus_bg_in(bus_bg_in),
        .bus_bg_out(bg_out), .bus_br(br), .bus_ssyn_out(ssyn_out),
        .bus_sack_out(sack_out), .bus_bbsy_out(bbsy_out), .bus_intr_out(intr_out),
        .bus_d_out(d_out)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 'o%0o, want 'o%0o", name, act, exp);
    endtask

    // Reference model: LKS bits, enabled-cycle count since clear, request state.
    bit          m_mon, m_ie, m_prev, m_pend, m_svc, m_write;
    int          m_n;
    logic [15:0] m_wd;
    logic [15:0] rq[$];
    logic [15:0] iq[$];

    task automatic model_clear();
        m_mon = 0; m_ie = 0; m_prev = 0; m_pend = 0; m_svc = 0; m_write = 0; m_n = 0;
    endtask

    task automatic step();
        bit cur;
        cur = m_mon & m_ie;
        @(posedge clk);
        if (bus_init) model_clear();
        else begin
            if (!m_pend && !m_svc) begin
                if (cur && !m_prev) m_pend = 1;
            end else if (m_pend) begin
                if (!cur) m_pend = 0;
                else if (bus_bg_in[6]) begin m_pend = 0; m_svc = 1; end
            end
            m_prev = cur;
            if (enable) begin
                m_n++;
                if (m_n % DIV == 0) m_mon = 1;
            end
            if (m_write) begin
                m_ie = m_wd[6];
                if (!m_wd[7]) m_mon = 0;
            end
        end
        m_write = 0;
        #1;
        chk("br", br, {1'b0, m_pend, 2'b00});
        chk("bg_out", bg_out, {bus_bg_in[7], bus_bg_in[6] & !(m_pend | m_svc), bus_bg_in[5:4]});
    endtask

    task automatic access(input logic [1:0] c, input logic [17:0] a, input logic [15:0] d);
        bit hit;
        hit = (a[17:1] == ADDR[17:1]);
        bus_addr = a; bus_c1 = c[1]; bus_c0 = c[0];
        bus_d = c[1] ? d : 16'h0;
        bus_msyn = 1;
        if (hit) begin
            rq.push_back(c[1] ? 16'h0 : {8'h00, m_mon, m_ie, 6'b000000});
            m_write = c[1] && !(c[0] && a[0]);
            m_wd = d;
        end
        step();
        chk("ssyn_on", ssyn_out, hit);
        repeat ($urandom_range(0, 2)) begin
            step();
            chk("ssyn_hold", ssyn_out, hit);
        end
        bus_msyn = 0;
        step();
        chk("ssyn_off", ssyn_out, 0);
        chk("d_off", d_out, 0);
        bus_addr = '0; bus_d = '0;
    endtask

    task automatic wait_req();
        for (int k = 0; k < 40 && !m_pend; k++) step();
        chk("req_raised", br[6], 1);
    endtask

    task automatic to_master();
        bus_bg_in[6] = 1; bus_bbsy = 1; bus_ssyn = 1;
        step();
        chk("grant_sack", sack_out, 1);
        bus_bg_in[6] = 0;
        repeat ($urandom_range(0, 2)) begin
            step();
            chk("grant_hold", sack_out, 1);
            chk("grant_no_intr", intr_out, 0);
        end
        bus_bbsy = 0; bus_ssyn = 0;
        iq.push_back(KW11L_VEC);
        step();
        chk("master_intr", intr_out, 1);
        chk("master_sack_off", sack_out, 0);
    endtask

    task automatic finish_service();
        repeat ($urandom_range(0, 2)) begin
            step();
            chk("master_hold", bbsy_out, 1);
        end
        bus_ssyn = 1; m_svc = 0;
        step();
        chk("done_intr", intr_out, 0);
        chk("done_bbsy", bbsy_out, 0);
        chk("done_sack", sack_out, 0);
        chk("done_d", d_out, 0);
        bus_ssyn = 0;
    endtask

    // Monitor: every rising ssyn_out / intr_out consumes one expected entry.
    logic prev_ssyn = 1'b0, prev_intr = 1'b0;
    always @(negedge clk) begin
        if (ssyn_out && !prev_ssyn) begin
            if (rq.size() == 0) begin
                n_chk++;
                $display("FAIL ssyn_unexpected: ssyn_out=1 with no access outstanding");
            end else chk("read_data", d_out, rq.pop_front());
        end
        if (intr_out && !prev_intr) begin
            if (iq.size() == 0) begin
                n_chk++;
                $display("FAIL intr_unexpected: intr_out=1 with no grant outstanding");
            end else begin
                chk("vector", d_out, iq.pop_front());
                chk("vector_bbsy", bbsy_out, 1);
            end
        end
        prev_ssyn = ssyn_out;
        prev_intr = intr_out;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_bg_in = 4'b1111; enable = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_br", br, 0);
        chk("rst_ssyn", ssyn_out, 0);
        chk("rst_sack", sack_out, 0);
        chk("rst_bbsy", bbsy_out, 0);
        chk("rst_intr", intr_out, 0);
        chk("rst_d", d_out, 0);
        chk("rst_bg_pass", bg_out, bus_bg_in);
        bus_bg_in = '0; reset = 1; model_clear();

        // First tick after 10 edges, IE=0 keeps br quiet.
        repeat (10) step();
        access(CYC_DATI, ADDR, 16'h0);
        access(CYC_DATO, ADDR, 16'o000100);
        access(CYC_DATI, ADDR, 16'h0);
        access(CYC_DATO, ADDR, 16'o000300);
        access(CYC_DATIP, ADDR, 16'h0);
        access(CYC_DATOB, ADDR | 18'd1, 16'o177777);
        access(CYC_DATI, ADDR, 16'h0);
        access(CYC_DATI, ADDR ^ 18'o10, 16'h0);

        wait_req();
        if (m_pend) begin to_master(); finish_service(); end

        // bus_init while master
        access(CYC_DATO, ADDR, 16'o000100);
        wait_req();
        if (m_pend) begin
            to_master();
            bus_bg_in = 4'b1111; bus_init = 1;
            step();
            chk("init_m_intr", intr_out, 0);
            chk("init_m_bbsy", bbsy_out, 0);
            chk("init_m_d", d_out, 0);
            bus_init = 0; bus_bg_in = '0;
        end
        access(CYC_DATI, ADDR, 16'h0);

        // bus_init during S_ACK
        bus_addr = ADDR; bus_c1 = 0; bus_c0 = 0; bus_msyn = 1;
        rq.push_back({8'h00, m_mon, m_ie, 6'b000000});
        step();
        chk("ack_pre_init", ssyn_out, 1);
        bus_init = 1;
        step();
        chk("init_s_ssyn", ssyn_out, 0);
        chk("init_s_d", d_out, 0);
        bus_init = 0; bus_msyn = 0;
        step();

        // Asynchronous reset mid-access and mid-count
        repeat (4) step();
        bus_addr = ADDR; bus_msyn = 1;
        rq.push_back({8'h00, m_mon, m_ie, 6'b000000});
        step();
        @(negedge clk);
        #1;
        reset = 0; bus_msyn = 0;
        #1;
        chk("areset_ssyn", ssyn_out, 0);
        chk("areset_d", d_out, 0);
        @(posedge clk);
        #1;
        reset = 1; model_clear();
        repeat (10) step();
        access(CYC_DATI, ADDR, 16'h0);

        for (int it = 0; it < 400; it++) begin
            int op;
            op = $urandom_range(0, 9);
            bus_bg_in[7] = 1'($urandom_range(0, 1));
            bus_bg_in[5] = 1'($urandom_range(0, 1));
            bus_bg_in[4] = 1'($urandom_range(0, 1));
            enable = ($urandom_range(0, 7) != 0);
            if (m_pend && $urandom_range(0, 1) == 1) begin
                to_master();
                finish_service();
            end else begin
                case (op)
                    0, 1: access(CYC_DATI, ADDR | 18'($urandom_range(0, 1)), 16'h0);
                    2:    access(CYC_DATIP, ADDR, 16'h0);
                    3, 4: access(CYC_DATO, ADDR, 16'($urandom));
                    5:    access(CYC_DATOB, ADDR | 18'($urandom_range(0, 1)), 16'($urandom));
                    6:    access(CYC_DATI, ADDR ^ (18'd2 << $urandom_range(0, 15)), 16'h0);
                    default: repeat ($urandom_range(1, 12)) step();
                endcase
            end
        end

        repeat (2) step();
        chk("rq_drained", rq.size(), 0);
        chk("iq_drained", iq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/kw11l.md
Name: kw11l

Overview:
- KW11-L line-time clock: a UNIBUS slave with one CSR (LKS) and a BR6 interrupt requester.
- Sits on the shared UNIBUS of the PDP-11/40 top level.
- Placed downstream of the TU58 DL11 in the bus-grant chain: its bus_bg_in takes that DL11's bus_bg_out.
- Its outputs are ORed into the top-level bus_d, bus_ssyn, bus_sack, bus_bbsy, bus_intr and bus_br wires, like every other slave.

Parameters:
- ADDR, 'o777546, LKS byte address; bit 0 is ignored for matching.
- VEC, 'o100, interrupt vector.
- CLK_HZ, 50000000, clk frequency.
- LINE_HZ, 60, tick rate; the period is CLK_HZ/LINE_HZ cycles.

Ports:
- clk  in  1  system clock; every register changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  front-panel line-clock enable; 0 freezes the prescaler.
- bus_init  in  1  UNIBUS INIT; synchronous clear.
- bus_d  in  16  wired-OR data bus.
- bus_addr  in  18  wired-OR address bus.
- bus_c0, bus_c1  in  1 each  cycle type: 00 DATI, 01 DATIP, 10 DATO, 11 DATOB.
- bus_bbsy, bus_msyn, bus_ssyn, bus_sack, bus_intr  in  1 each  wired-OR bus state.
- bus_bg_in  in  [7:4]  bus grants from upstream.
- bus_bg_out  out  [7:4]  bus grants to downstream.
- bus_br  out  [7:4]  bus request; only bit 6 is ever driven.
- bus_ssyn_out, bus_sack_out, bus_bbsy_out, bus_intr_out  out  1 each  this block's bus drives.
- bus_d_out  out  16  read data or vector; 0 whenever not driving.

Behaviour:
- Reset (reset low) and bus_init have identical effect:
  - clears LKS[7] (MON) and LKS[6] (IE);
  - clears the prescaler;
  - returns both FSMs to idle;
  - all outputs 0, except bus_bg_out = bus_bg_in.
- bus_init is sampled synchronously and overrides every other event on the same edge, including mid-cycle and mid-interrupt aborts.
- Prescaler:
  - counts 0..CLK_HZ/LINE_HZ-1 while enable=1, then wraps to 0;
  - on the wrap cycle, MON is set on the next edge.
  - enable=0 holds the count.
- Read data: {8'b0, MON, IE, 6'b0}. Bits other than 7:6 always read 0.
- Slave FSM (S_IDLE, S_ACK):
  - Match when bus_addr[17:1] == ADDR[17:1].
  - In S_IDLE, msyn=1 with a match moves to S_ACK on that edge.
  - In S_ACK, bus_ssyn_out=1; for DATI/DATIP, bus_d_out = read data, registered at entry.
  - DATO: on entry, IE <= bus_d[6]; MON cleared if bus_d[7]=0. Writing 1 to MON never sets it.
  - DATOB at even address: same as DATO. DATOB at odd address: acknowledged, no register change.
  - Leave S_ACK when msyn=0; ssyn_out and d_out drop on that edge.
  - One register access per msyn assertion.
  - Tick and write-0-to-MON on the same edge: the write wins, MON=0.
- Interrupt FSM (I_IDLE, I_REQ, I_GRANT, I_MASTER):
  - I_IDLE -> I_REQ on a rising edge of (MON & IE); the previous-cycle value is registered.
  - I_REQ: bus_br[6]=1.
    - MON or IE dropping returns to I_IDLE.
    - bus_bg_in[6]=1 moves to I_GRANT.
  - I_GRANT: br[6]=0, bus_sack_out=1. When bus_bbsy=0 and bus_ssyn=0, move to I_MASTER.
  - I_MASTER:
    - bus_bbsy_out=1, bus_intr_out=1, bus_d_out=VEC, sack_out=0;
    - on bus_ssyn=1 (CPU took the vector), all drops return to I_IDLE on that edge.
  - MON is not cleared by servicing. The next interrupt needs MON to clear and then set again, or IE to toggle.
- Grant pass-through:
  - bus_bg_out[6] = bus_bg_in[6] & (state == I_IDLE), combinational; bits 7, 5 and 4 pass straight.
  - A request armed on the same edge that bg_in[6] rises blocks the grant from the next cycle. Downstream devices tolerate one cycle of grant.
- bus_d_out is 0 unless in S_ACK(read) or I_MASTER. Both FSMs never drive in the same cycle: slave access needs the CPU as master.

Decomposition:
- Shared package unibus_pkg:
  - C1C0 encodings: DATI/DATIP/DATO/DATOB;
  - BR level indices 4..7;
  - the CSR address and vector constants as named localparams, reused by kl11/dl11.
- One sub-module: kw11l_tick, the prescaler. Inputs clk, reset, clear, enable; output tick pulse; parameter DIV = CLK_HZ/LINE_HZ.
- Slave and interrupt FSMs stay in kw11l.

Test Plan:
- CLK_HZ=600, LINE_HZ=60, enable=1, no accesses after reset -> MON sets 10 cycles after the counter starts and every 10 cycles after; br stays 0 because IE=0.
- DATI 'o777546 with MON=1, IE=0 -> ssyn_out on the edge after msyn; d_out = 'o000200; ssyn_out drops the edge after msyn falls.
- DATO 'o000100, then DATO 'o000300 -> after the first write LKS reads 'o000100 (MON cleared, IE set); the second write leaves MON unchanged.
- DATOB to 'o777547 with data 'o177777 -> ssyn asserted, LKS unchanged.
- IE=1, then a tick:
  - br[6] rises;
  - raise bg_in[6] -> sack_out=1, bg_out[6]=0;
  - drop bbsy/ssyn -> bbsy_out=1, intr_out=1, d_out='o100;
  - pulse ssyn -> all drops, I_IDLE.
- bus_init asserted while in I_MASTER and during S_ACK -> every output 0 next edge; LKS=0; bg_out passes bg_in; reset low mid-count also clears asynchronously.
